rr_sel_arbiter: RTL and testbench
=================================

Name: rr_sel_arbiter

Overview:
- Round-robin arbiter sitting directly upstream of the 8:1 3-bit channel mux; drives the mux select line.
- Accepts 8 channel request lines and grants one channel at a time.
- Holds the granted channel's select index stable until the downstream consumer acknowledges it.
- Rotates priority so that every requesting channel is served within 8 grants.

Parameters:
- N_CH, 8, number of channels; fixed at 8 to match the mux.
- SEL_W, 3, select width, equal to clog2(N_CH).
- HOLD_MAX, 16, grant timeout in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_CH  per-channel request; bit i requests channel i.
- ack  input  1  consumer done with current grant; sampled only while gnt_valid=1.
- sel  output SEL_W  registered channel index; connects to the mux select.
- gnt_valid  output 1  sel is valid and held.
- gnt_onehot  output N_CH  one-hot of sel when gnt_valid=1, otherwise 0.
- timeout  output 1  one-cycle pulse on forced release; constant 0 without the macro.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, sel=0, gnt_valid=0, gnt_onehot=0, ptr=0, timeout=0, hold counter=0.
- State IDLE:
  - If req!=0, pick the first set bit of req searching circularly from ptr upward: ptr, ptr+1, ..., 7, 0, ....
  - Register the winner into sel, set gnt_valid=1 and go to GRANT. Latency: req high in cycle n gives gnt_valid=1 in cycle n+1.
  - If req==0, stay in IDLE; sel keeps its last value.
- State GRANT:
  - sel and gnt_onehot are frozen. Changes on req are ignored, including the granted channel dropping its request.
  - On ack=1: set ptr=(sel+1) mod 8 (7 wraps to 0), then re-arbitrate the same cycle against current req, searching from the new ptr.
  - If a winner exists, stay in GRANT with the new sel next cycle. Back-to-back grants have no bubble and gnt_valid stays 1.
  - If no winner exists, go to IDLE with gnt_valid=0.
- Re-request after ack: the just-served channel may win again only if it is the sole requester, because it sits last in the rotation.
- ack while gnt_valid=0: ignored, with no state change.
- Reset mid-grant: outputs drop to reset values asynchronously; the pending grant is lost.
- Width rule: ptr is SEL_W bits and wraps naturally modulo 8.
- Invariant: gnt_onehot == (1<<sel) whenever gnt_valid=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on entry to GRANT and on every new grant, and increments every cycle in GRANT without ack.
  - When it reaches HOLD_MAX-1 with ack=0, the next edge performs a forced release identical to ack (ptr advance, re-arbitrate) and timeout pulses for one cycle.
  - ack and timeout in the same cycle count as a normal ack, with timeout=0.
- When undefined: no counter is generated, timeout is tied to 0, and a grant is held indefinitely until ack.

Decomposition:
- Package mux_pkg holds:
  - constants N_CH=8 and SEL_W=3;
  - typedef sel_t = logic[SEL_W-1:0];
  - typedef enum arb_state_t {IDLE, GRANT}.
- One combinational sub-module, rr_pick: inputs req and ptr; outputs found and idx. It is a circular priority encoder and is reused for both the IDLE and the re-arbitrate paths.

Test Plan:
- Reset then req=8'b0000_0100: gnt_valid=1 one cycle later with sel=2 and gnt_onehot=8'h04. Pulse ack with req=0: next cycle gnt_valid=0, and ptr=3 internally.
- ptr=0 and req=8'hFF, ack every cycle: sel sequence is 0,1,2,...,7,0 with gnt_valid held at 1 throughout (no bubble).
- Grant sel=7 with req=8'b1000_0001 held, then ack: next sel=0, which exercises ptr wrap.
- Grant sel=3, then drop req[3] and assert req[5] without ack for 10 cycles: sel stays 3. Then ack: sel=5.
- Assert rst asynchronously mid-GRANT with sel=6: sel=0, gnt_valid=0 and gnt_onehot=0 immediately, before the next edge.
- With ARB_TIMEOUT_EN and HOLD_MAX=4: grant sel=1 with req=8'h03 and no ack. After 4 GRANT cycles, timeout pulses once and sel=0. With the macro undefined, sel stays 1 indefinitely.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants and types for the 8:1 channel mux and its round-robin
// select arbiter (rr_sel_arbiter, rr_pick).
//   N_CH        : number of mux channels
//   SEL_W       : mux select width, clog2(N_CH)
//   sel_t       : channel index / select type
//   arb_state_t : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage : mux_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational circular priority encoder. Returns the first set bit of req
// found when searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
// Ports:
//   req   in  [N_CH-1:0]  request vector
//   ptr   in  sel_t       highest-priority index for this search
//   found out 1           at least one request bit is set
//   idx   out sel_t       winning index (equals ptr when found=0)
// -----------------------------------------------------------------------------
module rr_pick
  import mux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output logic            found,
  output sel_t            idx
);

  sel_t cand;

  // Walk offsets from farthest to nearest so the nearest hit (smallest
  // offset from ptr) is the last assignment and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_sel_arbiter.sv
// -----------------------------------------------------------------------------
// rr_sel_arbiter
// Round-robin arbiter driving the select line of the 8:1 channel mux. One
// channel is granted at a time; its index is held on sel until ack, after
// which priority rotates to the channel just past the served one and a new
// winner (if any) is granted on the very next cycle with no bubble.
//
// Optional feature (macro ARB_TIMEOUT_EN): a grant held for HOLD_MAX cycles
// without ack is force-released exactly as if ack had arrived, and timeout
// pulses for one cycle. Without the macro timeout is tied low and a grant is
// held indefinitely.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req        in   [N_CH-1:0] per-channel request
//   ack        in   consumer done with current grant (used only in GRANT)
//   sel        out  registered channel index to the mux select
//   gnt_valid  out  sel is valid and held
//   gnt_onehot out  one-hot of sel while gnt_valid, else 0
//   timeout    out  one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module rr_sel_arbiter
  import mux_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            ack,
  output sel_t            sel,
  output logic            gnt_valid,
  output logic [N_CH-1:0] gnt_onehot,
  output logic            timeout
);

  if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_hold_range_bad
    $error("rr_sel_arbiter: HOLD_MAX must be within 1..255");
  end

  arb_state_t      state_q, state_d;
  sel_t            sel_q, sel_d;
  sel_t            ptr_q, ptr_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [N_CH-1:0] onehot_q, onehot_d;

  sel_t            pick_ptr;
  logic            pick_found;
  sel_t            pick_idx;
  logic            force_w;
  logic            release_w;

  // One encoder serves both paths: from ptr when idle, from sel+1 when the
  // current grant is being released.
  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_ptr  = (state_q == GRANT) ? sel_q + sel_t'(1) : ptr_q;
  assign release_w = (state_q == GRANT) && (ack || force_w);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    gnt_valid_d = gnt_valid_q;
    onehot_d    = onehot_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          sel_d       = pick_idx;
          gnt_valid_d = 1'b1;
          onehot_d    = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
        end
      end
      GRANT: begin
        if (release_w) begin
          ptr_d = sel_q + sel_t'(1);
          if (pick_found) begin
            sel_d    = pick_idx;
            onehot_d = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
            onehot_d    = '0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
        onehot_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      gnt_valid_q <= 1'b0;
      onehot_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      gnt_valid_q <= gnt_valid_d;
      onehot_q    <= onehot_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q;
  logic       timeout_q;
  logic       new_grant;

  // ack takes precedence: a forced release is only flagged when ack is low.
  assign force_w   = (state_q == GRANT) && (hold_q == HOLD_LIM) && !ack;
  assign new_grant = pick_found && ((state_q == IDLE) || release_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_w;
      if (new_grant) begin
        hold_q <= '0;
      end else if ((state_q == GRANT) && !release_w) begin
        hold_q <= hold_q + 8'd1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign force_w = 1'b0;
  assign timeout = 1'b0;
`endif

  assign sel        = sel_q;
  assign gnt_valid  = gnt_valid_q;
  assign gnt_onehot = onehot_q;

endmodule : rr_sel_arbiter

// File: tb/tb_rr_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_sel_arbiter
// Directed self-checking bench for rr_sel_arbiter. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point, i.e. they show
// the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_rr_sel_arbiter;
  import mux_pkg::*;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] req;
  logic            ack;
  sel_t            sel;
  logic            gnt_valid;
  logic [N_CH-1:0] gnt_onehot;
  logic            timeout;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_CYC = 3;
`else
  localparam int HOLD_CYC = 10;
`endif

  rr_sel_arbiter #(.HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .sel        (sel),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({sel, gnt_valid, gnt_onehot, timeout} !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: sel=%0d gv=%b oh=%h to=%b, want 0/0/00/0",
               sel, gnt_valid, gnt_onehot, timeout);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'b0000_0100;
    step();
    tests_run++;
    if ({sel, gnt_valid, gnt_onehot} !== {3'd2, 1'b1, 8'h04}) begin
      tests_failed++;
      $display("FAIL single_grant: sel=%0d gv=%b oh=%h, want 2/1/04", sel, gnt_valid, gnt_onehot);
    end
    req = '0;
    ack = 1'b1;
    step();
    tests_run++;
    if ({gnt_valid, gnt_onehot, sel} !== {1'b0, 8'h00, 3'd2}) begin
      tests_failed++;
      $display("FAIL single_release: gv=%b oh=%h sel=%0d, want 0/00/2", gnt_valid, gnt_onehot, sel);
    end
    // ack held while idle must not change anything
    step();
    tests_run++;
    if ({gnt_valid, sel} !== {1'b0, 3'd2}) begin
      tests_failed++;
      $display("FAIL idle_ack: gv=%b sel=%0d, want 0/2", gnt_valid, sel);
    end
    ack = 1'b0;
    req = 8'hFF;
    step();
    tests_run++;
    if ({gnt_valid, sel, gnt_onehot} !== {1'b1, 3'd3, 8'h08}) begin
      tests_failed++;
      $display("FAIL ptr_after_ack: gv=%b sel=%0d oh=%h, want 1/3/08", gnt_valid, sel, gnt_onehot);
    end
  endtask

  task automatic test_back_to_back();
    sel_t exp;
    do_reset();
    req = 8'hFF;
    step();
    tests_run++;
    if ({gnt_valid, sel} !== {1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL b2b_first: gv=%b sel=%0d, want 1/0", gnt_valid, sel);
    end
    ack = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp = sel_t'(i);
      step();
      tests_run++;
      if ({gnt_valid, sel, gnt_onehot} !== {1'b1, exp, 8'h01 << exp}) begin
        tests_failed++;
        $display("FAIL b2b_step%0d: gv=%b sel=%0d oh=%h, want 1/%0d/%h",
                 i, gnt_valid, sel, gnt_onehot, exp, 8'h01 << exp);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'b1000_0000;
    step();
    tests_run++;
    if (sel !== 3'd7) begin
      tests_failed++;
      $display("FAIL wrap_grant7: sel=%0d, want 7", sel);
    end
    req = 8'b1000_0001;
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++;
    if ({gnt_valid, sel, gnt_onehot} !== {1'b1, 3'd0, 8'h01}) begin
      tests_failed++;
      $display("FAIL wrap_next: gv=%b sel=%0d oh=%h, want 1/0/01", gnt_valid, sel, gnt_onehot);
    end
  endtask

  task automatic test_sole_rerequest();
    do_reset();
    req = 8'b0000_0100;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++;
    if ({gnt_valid, sel} !== {1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL sole_rereq: gv=%b sel=%0d, want 1/2", gnt_valid, sel);
    end
    // channel 2 re-requests alongside 1: 1 must win since 2 sits last
    req = 8'b0000_0110;
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++;
    if (sel !== 3'd1) begin
      tests_failed++;
      $display("FAIL rereq_last: sel=%0d, want 1", sel);
    end
  endtask

  task automatic test_hold();
    int bad;
    do_reset();
    req = 8'b0000_1000;
    step();
    tests_run++;
    if (sel !== 3'd3) begin
      tests_failed++;
      $display("FAIL hold_grant: sel=%0d, want 3", sel);
    end
    req = 8'b0010_0000;
    bad = 0;
    for (int i = 0; i < HOLD_CYC; i++) begin
      step();
      if ({gnt_valid, sel, gnt_onehot} !== {1'b1, 3'd3, 8'h08}) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL hold_frozen: %0d cycles moved, last sel=%0d oh=%h, want 3/08", bad, sel, gnt_onehot);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++;
    if ({gnt_valid, sel, timeout} !== {1'b1, 3'd5, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold_ack: gv=%b sel=%0d to=%b, want 1/5/0", gnt_valid, sel, timeout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'b0100_0000;
    step();
    tests_run++;
    if (sel !== 3'd6) begin
      tests_failed++;
      $display("FAIL areset_grant: sel=%0d, want 6", sel);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({sel, gnt_valid, gnt_onehot} !== {3'd0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL areset_async: sel=%0d gv=%b oh=%h, want 0/0/00", sel, gnt_valid, gnt_onehot);
    end
    req = '0;
    #1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    // serve channel 0 first so ptr becomes 1
    req = 8'h01;
    step();
    req = '0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 8'h03;
    step();
    tests_run++;
    if ({gnt_valid, sel, timeout} !== {1'b1, 3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL to_grant: gv=%b sel=%0d to=%b, want 1/1/0", gnt_valid, sel, timeout);
    end
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      step();
      tests_run++;
      if ({sel, timeout} !== {3'd1, 1'b0}) begin
        tests_failed++;
        $display("FAIL to_wait%0d: sel=%0d to=%b, want 1/0", i, sel, timeout);
      end
    end
    step();
    tests_run++;
    if ({gnt_valid, sel, timeout} !== {1'b1, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL to_fire: gv=%b sel=%0d to=%b, want 1/0/1", gnt_valid, sel, timeout);
    end
    step();
    tests_run++;
    if ({sel, timeout} !== {3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL to_pulse: sel=%0d to=%b, want 0/0", sel, timeout);
    end
`else
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if ({gnt_valid, sel, timeout} !== {1'b1, 3'd1, 1'b0}) bad++;
      end
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL to_none: %0d cycles moved, last sel=%0d to=%b, want 1/0", bad, sel, timeout);
      end
    end
`endif
    req = '0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_sole_rerequest();
    test_hold();
    test_async_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_rr_sel_arbiter
